primary_ray_gen: RTL and testbench
==================================

Name: primary_ray_gen

Overview:
- Sits directly downstream of RenderState_Camera.
- Consumes its Camera output (U, V, W, RH, RV, BLC) plus the camera position, and walks the frame in raster order.
- Emits one primary ray (origin, unnormalised direction, pixel x/y) per pixel over a valid/ready handshake to the ray-traversal stage.
- Uses incremental accumulation, so only the 6-cycle setup uses multiplies.

Parameters:
- FRAC_BITS, 12, fractional bits of Fixed.Value; fixed multiply is (a*b) >>> FRAC_BITS, arithmetic shift, 64-bit intermediate.
- XW, 10, width of pixel x counter and the width input.
- YW, 10, width of pixel y counter and the height input.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- start  in  1  single-cycle frame start; ignored while busy=1
- camera  in  Camera  RenderState_Camera output; sampled only in SETUP/INIT
- pos  in  Fixed3  camera origin; captured on accepted start
- width  in  XW  pixels per row; captured on accepted start
- height  in  YW  rows; captured on accepted start
- inv_w  in  Fixed  1/width in Fixed; captured on accepted start
- inv_h  in  Fixed  1/height in Fixed; captured on accepted start
- ray_valid  out  1  ray output valid
- ray_ready  in  1  downstream accepts
- ray_org  out  Fixed3  ray origin (= captured pos)
- ray_dir  out  Fixed3  BLC - pos + x*DH + y*DV, unnormalised
- ray_x  out  XW  pixel column
- ray_y  out  YW  pixel row, 0 = bottom row
- busy  out  1  high from accepted start until done
- frame_done  out  1  one-cycle pulse at frame end

Behaviour:
- Reset (async, resetn=0): state=IDLE; ray_valid, busy, frame_done = 0; ray_org, ray_dir, ray_x, ray_y, DH, DV and accumulators = 0. Reset mid-frame abandons the frame with no done pulse.
- IDLE: start=1 captures pos, width, height, inv_w, inv_h; sets busy; goes to SETUP.
- SETUP: 6 cycles, one Fixed multiply per cycle, in order DH.x, DH.y, DH.z (RH*inv_w), then DV.x, DV.y, DV.z (RV*inv_h). Then INIT.
- INIT: 1 cycle. row_base = dir = BLC - pos (per-dim 32-bit wrap add); x = y = 0.
  - width=0 or height=0: go to DONE with no rays.
  - Otherwise go to EMIT.
- EMIT: ray_valid=1 with the current x, y, dir, org.
  - First ray_valid is high exactly 8 cycles after the start-sampling edge.
  - Outputs are held stable while ray_valid && !ray_ready.
  - On transfer with x < width-1: x++, dir += DH.
  - On transfer with x = width-1: x=0, y++, row_base += DV, dir = row_base + DV.
  - On transfer of pixel (width-1, height-1): ray_valid drops next cycle; go to DONE.
  - No bubbles: back-to-back transfers every cycle while ray_ready=1.
- DONE: frame_done=1 for one cycle, busy=0, return to IDLE. A new start is accepted from IDLE on the following cycle.
- Arithmetic: all adds wrap modulo 2^32 per dimension, with no saturation. Counters compare with ==, and width/height up to 2^XW-1 / 2^YW-1 are supported.
- start asserted while busy has no effect; captured values are unchanged.

Optional Feature:
- Macro: PRIMARY_RAY_JITTER_EN.
- Defined: a 16-bit Galois LFSR (poly 0xB400, seed 0xACE1 at reset) advances on each transfer.
  - Emitted ray_dir = accumulated dir + ((lfsr[3:0]-8) * DH >>> 4) + ((lfsr[7:4]-8) * DV >>> 4), applied per dim.
  - The accumulators themselves are not jittered.
  - Adds one output register stage, so first valid is at 9 cycles.
- Not defined: no LFSR, and ray_dir equals the accumulated dir exactly.

Test Plan:
- Common setup: pos=(0,0,0), BLC=(-4,-3,-1), RH=(8,0,0), RV=(0,6,0), width=4, height=3, inv_w=1024, inv_h=1365, ray_ready=1.
- Setup/first ray: start with the common setup -> DH.x=8192, DV.y=8190; at cycle 8 ray_valid=1, (x,y)=(0,0), ray_dir=(-16384,-12288,-4096).
- Raster/accumulation: same run -> 12 consecutive transfers; (3,0) dir.x=8192; (0,2) dir.y=4092; frame_done pulses one cycle after the 12th transfer; busy falls with it.
- Backpressure: drop ray_ready for 5 cycles at pixel (1,1) -> outputs held constant; no skipped or duplicated pixels; total count still 12.
- Degenerate: width=0 -> no ray_valid; frame_done exactly 8 cycles after start; start while busy is ignored (captured width unchanged).
- Reset mid-frame: resetn=0 after pixel (2,1) -> all outputs 0 immediately; after release a new start produces (0,0) with the first-ray values above.

Source files
------------

// File: rtl/primary_ray_gen.sv
// primary_ray_gen: raster-order primary ray generator.
// It takes the camera basis and computes the per-pixel steps
// DH = RH/width and DV = RV/height. It does this with one shared fixed-point
// multiplier over 6 setup cycles. It then walks the frame with adds only.
// Optional feature macro: PRIMARY_RAY_JITTER_EN. It adds LFSR sub-pixel jitter
// and one output register stage.

package primary_ray_gen_pkg;
    typedef logic signed [31:0] fixed_t;
    typedef struct packed { fixed_t x; fixed_t y; fixed_t z; } fixed3_t;
    typedef struct packed { fixed3_t u, v, w, rh, rv, blc; } camera_t;

    function automatic fixed3_t add3(input fixed3_t a, input fixed3_t b);
        return '{a.x + b.x, a.y + b.y, a.z + b.z};
    endfunction

    function automatic fixed3_t sub3(input fixed3_t a, input fixed3_t b);
        return '{a.x - b.x, a.y - b.y, a.z - b.z};
    endfunction
endpackage

module primary_ray_gen
    import primary_ray_gen_pkg::*;
#(
    parameter int FRAC_BITS = 12,
    parameter int XW        = 10,
    parameter int YW        = 10
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start,
    input  camera_t       camera,
    input  fixed3_t       pos,
    input  logic [XW-1:0] width,
    input  logic [YW-1:0] height,
    input  fixed_t        inv_w,
    input  fixed_t        inv_h,
    output logic          ray_valid,
    input  logic          ray_ready,
    output fixed3_t       ray_org,
    output fixed3_t       ray_dir,
    output logic [XW-1:0] ray_x,
    output logic [YW-1:0] ray_y,
    output logic          busy,
    output logic          frame_done
);
    typedef enum logic [2:0] {IDLE, SETUP, INIT, EMIT, DONE} state_t;

    state_t        state;
    logic [2:0]    cnt;
    fixed3_t       c_pos, dh, dv, row_base, dir;
    logic [XW-1:0] c_w, x;
    logic [YW-1:0] c_h, y;
    fixed_t        c_iw, c_ih;
    logic          acc_valid, acc_ready, out_busy, tx;
    fixed_t        mul_a, mul_b, mul_q;
    logic signed [63:0] prod;

    // U/V/W are part of the camera bundle but only RH/RV/BLC drive primary rays.
    logic unused_cam;
    assign unused_cam = ^{camera.u, camera.v, camera.w};

    // Shared setup multiplier: the operand is selected by the setup step.
    always_comb begin
        mul_a = '0;
        case (cnt)
            3'd0:    mul_a = camera.rh.x;
            3'd1:    mul_a = camera.rh.y;
            3'd2:    mul_a = camera.rh.z;
            3'd3:    mul_a = camera.rv.x;
            3'd4:    mul_a = camera.rv.y;
            default: mul_a = camera.rv.z;
        endcase
        mul_b = (cnt < 3'd3) ? c_iw : c_ih;
        prod  = 64'(mul_a) * 64'(mul_b);
        mul_q = fixed_t'(prod >>> FRAC_BITS);
    end

    assign tx = acc_valid && acc_ready;

    // Control FSM and the incremental raster accumulators.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            cnt        <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            acc_valid  <= 1'b0;
            c_pos      <= '0;
            c_w        <= '0;
            c_h        <= '0;
            c_iw       <= '0;
            c_ih       <= '0;
            dh         <= '0;
            dv         <= '0;
            row_base   <= '0;
            dir        <= '0;
            x          <= '0;
            y          <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    c_pos <= pos;
                    c_w   <= width;
                    c_h   <= height;
                    c_iw  <= inv_w;
                    c_ih  <= inv_h;
                    busy  <= 1'b1;
                    cnt   <= '0;
                    state <= SETUP;
                end
                SETUP: begin
                    case (cnt)
                        3'd0:    dh.x <= mul_q;
                        3'd1:    dh.y <= mul_q;
                        3'd2:    dh.z <= mul_q;
                        3'd3:    dv.x <= mul_q;
                        3'd4:    dv.y <= mul_q;
                        default: dv.z <= mul_q;
                    endcase
                    cnt <= cnt + 3'd1;
                    if (cnt == 3'd5) state <= INIT;
                end
                INIT: begin
                    row_base <= sub3(camera.blc, c_pos);
                    dir      <= sub3(camera.blc, c_pos);
                    x        <= '0;
                    y        <= '0;
                    state    <= (c_w == '0 || c_h == '0) ? DONE : EMIT;
                end
                EMIT: begin
                    // acc_valid is low in EMIT only on entry; raise it, then stream.
                    if (!acc_valid) begin
                        acc_valid <= 1'b1;
                    end else if (tx) begin
                        if (x != c_w - XW'(1)) begin
                            x   <= x + XW'(1);
                            dir <= add3(dir, dh);
                        end else if (y == c_h - YW'(1)) begin
                            acc_valid <= 1'b0;
                            state     <= DONE;
                        end else begin
                            x        <= '0;
                            y        <= y + YW'(1);
                            row_base <= add3(row_base, dv);
                            dir      <= add3(row_base, dv);
                        end
                    end
                end
                DONE: if (!out_busy) begin
                    frame_done <= 1'b1;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef PRIMARY_RAY_JITTER_EN
    logic [15:0] lfsr;

    // Signed nibble offset (-8..7) times step, scaled by 1/16.
    function automatic fixed_t jit(input logic [3:0] n, input fixed_t d);
        logic signed [39:0] m, p;
        m = $signed({36'd0, n}) - 40'sd8;
        p = m * 40'(d);
        return fixed_t'(p >>> 4);
    endfunction

    assign acc_ready = !ray_valid || ray_ready;
    assign out_busy  = ray_valid;

    // Output stage: applies jitter to the emitted dir only; accumulators stay exact.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lfsr      <= 16'hACE1;
            ray_valid <= 1'b0;
            ray_org   <= '0;
            ray_dir   <= '0;
            ray_x     <= '0;
            ray_y     <= '0;
        end else begin
            if (ray_valid && ray_ready)
                lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
            if (acc_ready) begin
                ray_valid <= acc_valid;
                if (acc_valid) begin
                    ray_org   <= c_pos;
                    ray_x     <= x;
                    ray_y     <= y;
                    ray_dir.x <= dir.x + jit(lfsr[3:0], dh.x) + jit(lfsr[7:4], dv.x);
                    ray_dir.y <= dir.y + jit(lfsr[3:0], dh.y) + jit(lfsr[7:4], dv.y);
                    ray_dir.z <= dir.z + jit(lfsr[3:0], dh.z) + jit(lfsr[7:4], dv.z);
                end
            end
        end
    end
`else
    assign acc_ready = ray_ready;
    assign out_busy  = 1'b0;
    assign ray_valid = acc_valid;
    assign ray_org   = c_pos;
    assign ray_dir   = dir;
    assign ray_x     = x;
    assign ray_y     = y;
`endif

endmodule

// File: tb/tb_primary_ray_gen.sv
// Directed bench for primary_ray_gen: 4x3 frame, backpressure, degenerate, mid-frame reset.
module tb_primary_ray_gen;
    import primary_ray_gen_pkg::*;

    logic       clk = 1'b0;
    logic       resetn, start, ray_ready;
    camera_t    camera;
    fixed3_t    pos;
    logic [9:0] width, height;
    fixed_t     inv_w, inv_h;
    logic       ray_valid, busy, frame_done;
    fixed3_t    ray_org, ray_dir;
    logic [9:0] ray_x, ray_y;

    int total = 0;
    int bad   = 0;

    primary_ray_gen #(.FRAC_BITS(12), .XW(10), .YW(10)) u_dut (
        .clk(clk), .resetn(resetn), .start(start), .camera(camera), .pos(pos),
        .width(width), .height(height), .inv_w(inv_w), .inv_h(inv_h),
        .ray_valid(ray_valid), .ray_ready(ray_ready), .ray_org(ray_org),
        .ray_dir(ray_dir), .ray_x(ray_x), .ray_y(ray_y), .busy(busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Expected direction for pixel (px,py): BLC + px*DH + py*DV with DH.x=8192, DV.y=8190.
    task automatic chk_dir(input string tag, input int px, input int py);
        chk({tag, ".x"}, ray_dir.x, -16384 + px * 8192);
        chk({tag, ".y"}, ray_dir.y, -12288 + py * 8190);
        chk({tag, ".z"}, ray_dir.z, -4096);
    endtask

    task automatic start_frame;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic first_ray;
        repeat (7) tick();
        chk("valid_before_8", ray_valid, 0);
        tick();
        chk("valid_at_8", ray_valid, 1);
        chk("first_x", ray_x, 0);
        chk("first_y", ray_y, 0);
        chk_dir("first_dir", 0, 0);
    endtask

    // Streams n transfers in raster order; optionally stalls 5 cycles before pixel index stall_at.
    task automatic stream(input int stall_at, input int n);
        fixed3_t    sd;
        logic [9:0] sx, sy;
        for (int i = 0; i < n; i++) begin
            chk("stream_valid", ray_valid, 1);
            if (i == stall_at) begin
                ray_ready = 1'b0;
                sd = ray_dir;
                sx = ray_x;
                sy = ray_y;
                repeat (5) begin
                    tick();
                    chk("hold_valid", ray_valid, 1);
                    chk("hold_x", ray_x, sx);
                    chk("hold_y", ray_y, sy);
                    chk("hold_dir", ray_dir, sd);
                end
                ray_ready = 1'b1;
            end
            chk("px_x", ray_x, i % 4);
            chk("px_y", ray_y, i / 4);
            chk_dir("px_dir", i % 4, i / 4);
            if (i == 3) chk("dir_x_3_0", ray_dir.x, 8192);
            if (i == 8) chk("dir_y_0_2", ray_dir.y, 4092);
            tick();
        end
    endtask

    task automatic end_frame;
        chk("valid_drop", ray_valid, 0);
        chk("done_early", frame_done, 0);
        chk("busy_last", busy, 1);
        tick();
        chk("done_pulse", frame_done, 1);
        chk("busy_fall", busy, 0);
        tick();
        chk("done_one_cycle", frame_done, 0);
    endtask

    initial begin
        camera     = '0;
        camera.blc = '{-32'sd16384, -32'sd12288, -32'sd4096};
        camera.rh  = '{32'sd32768, 32'sd0, 32'sd0};
        camera.rv  = '{32'sd0, 32'sd24576, 32'sd0};
        pos        = '0;
        width      = 10'd4;
        height     = 10'd3;
        inv_w      = 32'sd1024;
        inv_h      = 32'sd1365;
        start      = 1'b0;
        ray_ready  = 1'b1;
        resetn     = 1'b0;

        // Reset state
        #12;
        chk("rst_valid", ray_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", frame_done, 0);
        chk("rst_dir", ray_dir, 0);
        chk("rst_org", ray_org, 0);
        tick();
        resetn = 1'b1;
        tick();

        // Plain frame
        start_frame();
        first_ray();
        chk("dh_x", u_dut.dh.x, 8192);
        chk("dv_y", u_dut.dv.y, 8190);
        chk("org", ray_org, 0);
        stream(-1, 12);
        end_frame();

        // Backpressure at pixel (1,1)
        start_frame();
        first_ray();
        stream(5, 12);
        end_frame();

        // Degenerate width, with start retried while busy
        width = 10'd0;
        start_frame();
        start = 1'b1;
        width = 10'd4;
        repeat (3) begin
            tick();
            chk("degen_valid", ray_valid, 0);
            chk("degen_done_early", frame_done, 0);
        end
        start = 1'b0;
        repeat (4) begin
            tick();
            chk("degen_valid", ray_valid, 0);
            chk("degen_done_early", frame_done, 0);
        end
        tick();
        chk("degen_done_at_8", frame_done, 1);
        chk("degen_valid_8", ray_valid, 0);
        chk("degen_busy", busy, 0);
        chk("captured_width", u_dut.c_w, 0);
        tick();
        chk("degen_done_one", frame_done, 0);

        // Reset mid-frame after pixel (2,1)
        start_frame();
        first_ray();
        stream(-1, 7);
        chk("pre_rst_x", ray_x, 3);
        resetn = 1'b0;
        #1;
        chk("mid_rst_valid", ray_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", frame_done, 0);
        chk("mid_rst_dir", ray_dir, 0);
        chk("mid_rst_x", ray_x, 0);
        chk("mid_rst_y", ray_y, 0);
        tick();
        chk("rst_no_done", frame_done, 0);
        resetn = 1'b1;
        tick();
        start_frame();
        first_ray();
        stream(-1, 12);
        end_frame();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
